// File: rtl/call_stack.sv
// call_stack
//
// Hardware return-address stack for the multicycle CPU. JAL pushes its
// return address during the ST stage; the stop-bit return path pops the
// saved address back to the PC source mux (PCsrc=0 input).
//
// Parameters:
//   DATA_W - width of one stored address
//   DEPTH  - number of entries (at least 2)
//   CNT_W  - width of the count output
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   st_stage   - high while the control FSM sits in ST_STAGE; qualifies ops
//   StW        - push strobe from the control unit
//   StR        - pop strobe from the control unit
//   push_data  - return address to push (PC+1)
//   clr_err    - synchronous clear of both sticky error flags
//   top_data   - combinational top entry, 0 when empty
//   pop_data   - registered value of the last successful pop
//   pop_valid  - one-cycle pulse in the cycle after a successful pop
//   count      - number of valid entries, 0..DEPTH
//   empty      - count == 0
//   full       - count == DEPTH
//   overflow   - sticky, set by a push to a full stack
//   underflow  - sticky, set by a pop from an empty stack

module call_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_stage,
  input  logic              StW,
  input  logic              StR,
  input  logic [DATA_W-1:0] push_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] top_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp;
  logic [CNT_W-1:0]  sp_m1;
  logic [CNT_W-1:0]  sp_next;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     wr_idx;
  logic              mem_we;
  logic              pop_fire;
  logic              ov_set;
  logic              un_set;
  logic              do_push;
  logic              do_pop;
  logic              do_repl;

  assign sp_m1   = sp - CNT_W'(1);
  assign top_idx = sp_m1[AW-1:0];
  assign empty   = (sp == '0);
  assign full    = (sp == CNT_W'(DEPTH));
  assign count   = sp;

  // Gated so that stale contents never leak out once the stack is empty.
  assign top_data = empty ? '0 : mem[top_idx];

  // Decode the three operation kinds and their effects on pointer, storage
  // and error flags. A push+pop on an empty stack degrades to a plain push
  // that also records the failed pop half as an underflow.
  always_comb begin
    do_push  = st_stage & StW & ~StR;
    do_pop   = st_stage & StR & ~StW;
    do_repl  = st_stage & StW & StR;
    mem_we   = 1'b0;
    wr_idx   = sp[AW-1:0];
    sp_next  = sp;
    pop_fire = 1'b0;
    ov_set   = 1'b0;
    un_set   = 1'b0;

    if (do_push) begin
      if (full) begin
        ov_set = 1'b1;
      end else begin
        mem_we  = 1'b1;
        sp_next = sp + CNT_W'(1);
      end
    end else if (do_pop) begin
      if (empty) begin
        un_set = 1'b1;
      end else begin
        pop_fire = 1'b1;
        sp_next  = sp_m1;
      end
    end else if (do_repl) begin
      if (empty) begin
        // DEPTH >= 2 guarantees an empty stack is never full.
        mem_we  = 1'b1;
        sp_next = sp + CNT_W'(1);
        un_set  = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_idx   = top_idx;
        pop_fire = 1'b1;
      end
    end
  end

  // Storage has no reset; its contents are hidden behind the empty gate.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Pointer, pop result and sticky flags. An error event in the same cycle
  // as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      pop_valid <= pop_fire;
      if (pop_fire) begin
        pop_data <= mem[top_idx];
      end
      if (ov_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (un_set) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack
//
// Directed bench for call_stack at DEPTH=4. Stimulus pushes the expected
// pop result into a queue whenever it issues a successful pop; a separate
// monitor drains the queue each time the DUT raises pop_valid. Status
// outputs are compared directly against hand-computed values.

module tb_call_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              st_stage;
  logic              StW;
  logic              StR;
  logic [DATA_W-1:0] push_data;
  logic              clr_err;
  logic [DATA_W-1:0] top_data;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int checks;
  int errors;
  logic [DATA_W-1:0] exp_q [$];

  call_stack #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_stage (st_stage),
    .StW      (StW),
    .StR      (StR),
    .push_data(push_data),
    .clr_err  (clr_err),
    .top_data (top_data),
    .pop_data (pop_data),
    .pop_valid(pop_valid),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  // Scoreboard monitor: every pop_valid pulse must match the oldest
  // expected pop value; a pulse with nothing expected is spurious.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && pop_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL spurious_pop_valid got pop_data=%h with nothing expected", pop_data);
        end else begin
          logic [DATA_W-1:0] exp_v;
          exp_v = exp_q.pop_front();
          if (pop_data !== exp_v) begin
            errors++;
            $display("[TB] FAIL pop_data got %h expected %h", pop_data, exp_v);
          end
        end
      end
    end
  end

  task automatic compareField(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Snapshot of every status output against expected values.
  task automatic checkOutput(input string tag, input int exp_count,
                             input logic exp_empty, input logic exp_full,
                             input logic [DATA_W-1:0] exp_top,
                             input logic [DATA_W-1:0] exp_pd,
                             input logic exp_pv, input logic exp_ov,
                             input logic exp_un);
    compareField({tag, ".count"},     DATA_W'(count),     DATA_W'(exp_count));
    compareField({tag, ".empty"},     DATA_W'(empty),     DATA_W'(exp_empty));
    compareField({tag, ".full"},      DATA_W'(full),      DATA_W'(exp_full));
    compareField({tag, ".top_data"},  top_data,           exp_top);
    compareField({tag, ".pop_data"},  pop_data,           exp_pd);
    compareField({tag, ".pop_valid"}, DATA_W'(pop_valid), DATA_W'(exp_pv));
    compareField({tag, ".overflow"},  DATA_W'(overflow),  DATA_W'(exp_ov));
    compareField({tag, ".underflow"}, DATA_W'(underflow), DATA_W'(exp_un));
  endtask

  // One operation cycle: drive at the falling edge, let the rising edge
  // take it, then return inputs to idle 1 unit later for sampling.
  task automatic applyStimulus(input logic st, input logic w, input logic r,
                               input logic [DATA_W-1:0] d, input logic clr,
                               input logic expect_pop,
                               input logic [DATA_W-1:0] pop_exp);
    @(negedge clk);
    st_stage  = st;
    StW       = w;
    StR       = r;
    push_data = d;
    clr_err   = clr;
    if (expect_pop) exp_q.push_back(pop_exp);
    @(posedge clk);
    #1;
    st_stage  = 1'b0;
    StW       = 1'b0;
    StR       = 1'b0;
    push_data = '0;
    clr_err   = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0, '0);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic asyncReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    st_stage  = 1'b0;
    StW       = 1'b0;
    StR       = 1'b0;
    push_data = '0;
    clr_err   = 1'b0;
    #3;
    checkOutput("reset", 0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic push / pop ordering.
    push(32'h10);
    push(32'h20);
    push(32'h30);
    checkOutput("push3", 3, 1'b0, 1'b0, 32'h30, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1, 32'h30);
    checkOutput("pop1", 2, 1'b0, 1'b0, 32'h20, 32'h30, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("pop1_idle", 2, 1'b0, 1'b0, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1, 32'h20);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1, 32'h10);
    checkOutput("pop_to_empty", 0, 1'b1, 1'b0, '0, 32'h10, 1'b1, 1'b0, 1'b0);

    // Underflow from empty: pop_data keeps 0x10.
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    checkOutput("underflow", 0, 1'b1, 1'b0, '0, 32'h10, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("clr_under", 0, 1'b1, 1'b0, '0, 32'h10, 1'b0, 1'b0, 1'b0);

    // Fill, overflow, clear, set-wins-over-clear.
    push(32'hA);
    push(32'hB);
    push(32'hC);
    push(32'hD);
    checkOutput("full", 4, 1'b0, 1'b1, 32'hD, 32'h10, 1'b0, 1'b0, 1'b0);
    push(32'hE);
    checkOutput("overflow", 4, 1'b0, 1'b1, 32'hD, 32'h10, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("clr_over", 4, 1'b0, 1'b1, 32'hD, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hF, 1'b1, 1'b0, '0);
    checkOutput("set_wins", 4, 1'b0, 1'b1, 32'hD, 32'h10, 1'b0, 1'b1, 1'b0);
    // Replace-top on a full stack is legal and raises no error.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 32'hD);
    checkOutput("repl_full", 4, 1'b0, 1'b1, 32'h44, 32'hD, 1'b1, 1'b0, 1'b0);

    // Replace-top on [0x5, 0x6].
    asyncReset();
    push(32'h5);
    push(32'h6);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h9, 1'b0, 1'b1, 32'h6);
    checkOutput("replace", 2, 1'b0, 1'b0, 32'h9, 32'h6, 1'b1, 1'b0, 1'b0);

    // Strobes ignored outside the ST stage.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0, '0);
    checkOutput("no_st_push", 2, 1'b0, 1'b0, 32'h9, 32'h6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    checkOutput("no_st_pop", 2, 1'b0, 1'b0, 32'h9, 32'h6, 1'b0, 1'b0, 1'b0);

    // Replace on empty: plain push plus underflow.
    asyncReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 1'b0, '0);
    checkOutput("repl_empty", 1, 1'b0, 1'b0, 32'h77, '0, 1'b0, 1'b0, 1'b1);

    // Reset between push edges after two pushes.
    asyncReset();
    push(32'h1);
    push(32'h2);
    checkOutput("pre_reset", 2, 1'b0, 1'b0, 32'h2, '0, 1'b0, 1'b0, 1'b0);
    asyncReset();
    idleCycle();
    checkOutput("post_reset", 0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Every expected pop must have been seen by the monitor.
    idleCycle();
    compareField("scoreboard_drained", DATA_W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_stack.md
# call_stack

Hardware return-address stack for the multicycle CPU. It sits downstream of the control unit and consumes the `StW` (push) and `StR` (pop) strobes that the control unit raises for the ST stage. JAL pushes its return address. The stop-bit return path pops a saved address back to the PC source mux. The block owns the stack storage, the stack pointer, the full/empty status and the sticky overflow/underflow error flags.

## Interface
Parameters:
- `DATA_W`, default 32: width of a stored address.
- `DEPTH`, default 16: number of entries. Must be at least 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `count`.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `st_stage` input 1: high while the control FSM is in ST_STAGE (state 5). Operations are qualified by this signal.
- `StW` input 1: push request from the control unit.
- `StR` input 1: pop request from the control unit.
- `push_data` input DATA_W: return address to push (PC+1, supplied by the datapath).
- `clr_err` input 1: synchronous clear of both sticky error flags.
- `top_data` output DATA_W: combinational view of the top entry. Reads 0 when empty.
- `pop_data` output DATA_W: registered value of the last successful pop. Feeds the PCsrc=0 input of the PC mux.
- `pop_valid` output 1: one-cycle pulse in the cycle after a successful pop.
- `count` output CNT_W: number of valid entries, 0..DEPTH.
- `empty` output 1: high when count==0.
- `full` output 1: high when count==DEPTH.
- `overflow` output 1: sticky; set by a push to a full stack.
- `underflow` output 1: sticky; set by a pop from an empty stack.

## Operation
- Storage: DEPTH×DATA_W register array plus a stack pointer `sp`, where `sp` equals `count`. The top entry is `mem[sp-1]`.
- No operation is performed when `st_stage` is 0, regardless of `StW`/`StR`.
- Push (`st_stage & StW & !StR`):
  - Not full: `mem[sp] <= push_data`, `sp <= sp+1`.
  - Full: no write, `sp` unchanged, `overflow <= 1`.
- Pop (`st_stage & StR & !StW`):
  - Not empty: `pop_data <= mem[sp-1]`, `sp <= sp-1`, `pop_valid <= 1`.
  - Empty: `pop_data` unchanged, `pop_valid` stays 0, `underflow <= 1`.
- Simultaneous push and pop (`st_stage & StW & StR`) means replace-top:
  - Not empty: `pop_data <= mem[sp-1]`, `mem[sp-1] <= push_data`, `sp` unchanged, `pop_valid <= 1`.
  - Empty: behaves as a plain push, and also sets `underflow <= 1`. `pop_valid` stays 0.
- `pop_valid` is 0 in every cycle that does not follow a successful pop.
- `clr_err`:
  - Clears `overflow` and `underflow` at the next edge.
  - If an error event occurs in the same cycle, the set wins.
- The pointer never wraps. It saturates at 0 and at DEPTH, and the error flags record any attempt to go past those limits.
- `top_data = empty ? 0 : mem[sp-1]`. It is purely combinational from `sp` and `mem`.

## Timing
- Reset (`rst_n` low, asynchronous) clears:
  - `sp`/`count` to 0, `empty` to 1, `full` to 0.
  - `pop_data` to 0, `pop_valid` to 0.
  - `overflow` to 0, `underflow` to 0.
- Memory contents are not reset. They are unobservable because `top_data` is gated when empty.
- Reset asserted mid-operation aborts any pending update. The stack is empty from the reset edge onward.
- Latency from the `st_stage` cycle:
  - One edge for the `sp`/`count`/`full`/`empty` update.
  - `pop_data` and `pop_valid` are valid in the cycle after the ST stage, which is the IF stage. The PC register samples `pop_data` at the end of that IF cycle.
- `top_data` reflects a push in the cycle immediately after it.
- The control unit holds ST_STAGE for exactly one cycle per instruction, so at most one operation occurs per instruction. If `st_stage` is held longer, one operation is performed per cycle; no edge detection is done.

## Test plan
- Reset, then check: `count`=0, `empty`=1, `full`=0, `top_data`=0, `pop_data`=0, both flags 0.
- DEPTH=4:
  - Push 0x10, 0x20, 0x30 (each with one `st_stage` cycle) → `count`=3, `top_data`=0x30.
  - Then pop → next cycle `pop_data`=0x30, `pop_valid`=1 for exactly one cycle, `count`=2, `top_data`=0x20.
- DEPTH=4, push 0xA,0xB,0xC,0xD → `full`=1. Push 0xE → `count` stays 4, `overflow`=1, `top_data`=0xD. Then `clr_err` → `overflow`=0.
- From empty, pop → `underflow`=1, `pop_valid`=0, `pop_data` keeps its previous value, `count`=0.
- Stack holding [0x5,0x6], assert `StW`&`StR` with `push_data`=0x9 → `pop_data`=0x6, `pop_valid`=1, `count`=2, `top_data`=0x9.
- Raise `StW` with `st_stage`=0 → no change. Assert `rst_n` low between push edges after two pushes → `count`=0 immediately, without waiting for a clock edge.
